// File: rtl/bcd_pkg.sv
// +----------------------------------------------------------------------+
// | bcd_pkg : shared types and helpers for the BCD-to-binary converter    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Smallest output width that holds every value up to 10**digits - 1 exactly.
    function automatic int digits_to_bw(input int digits);
        longint unsigned top;
        int              bits;
        top  = 1;
        bits = 0;
        for (int i = 0; i < digits; i++) begin
            top = top * 10;
        end
        for (int b = 0; b < 64; b++) begin
            if ((64'd1 << b) < top) begin
                bits = b + 1;
            end
        end
        return bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mac10.sv
// +----------------------------------------------------------------------+
// | bcd_mac10 : combinational acc*10 + digit using shifts and adds only   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BW = 10
) (
    input  logic [BW-1:0] acc_i,
    input  bcd_digit_t    digit_i,
    output logic [BW-1:0] acc_o
);

    // 10*acc = 8*acc + 2*acc; everything wraps at BW bits.
    assign acc_o = (acc_i << 3) + (acc_i << 1) + BW'(digit_i);

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin.sv
// +----------------------------------------------------------------------+
// | bcd_to_bin : packed-BCD to binary, one digit per clock, MSD first.    |
// | Optional invalid-digit flag with BCD_TO_BIN_DIGIT_CHECK_EN.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BW     = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIGITS*4-1:0] bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BW-1:0]       bin
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    ,
    output logic                err
`endif
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    generate
        if (DIGITS < 1) begin : g_bad_digits
            $error("bcd_to_bin: DIGITS must be at least 1");
        end
        if (BW < digits_to_bw(DIGITS)) begin : g_wrap
            $warning("bcd_to_bin: BW too narrow, results wrap modulo 2**BW");
        end
    endgenerate

    conv_state_t         state_q, state_d;
    logic [DIGITS*4-1:0] sreg_q, sreg_d;
    logic [BW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bin_q, bin_d;
    bcd_digit_t          msd;
    logic [BW-1:0]       mac_sum;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    logic                flag_q, flag_d;
    logic                err_q, err_d;
`endif

    assign msd = sreg_q[DIGITS*4-1 -: 4];

    bcd_mac10 #(
        .BW (BW)
    ) u_mac (
        .acc_i   (acc_q),
        .digit_i (msd),
        .acc_o   (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
            flag_q  <= flag_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        flag_d  = flag_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = bcd;
                    acc_d   = '0;
                    cnt_d   = CW'(DIGITS - 1);
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
                    flag_d  = 1'b0;
`endif
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d  = mac_sum;
                sreg_d = sreg_q << 4;
                cnt_d  = cnt_q - CW'(1);
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
                flag_d = flag_q | (msd > BCD_MAX);
`endif
                // Last digit: the MAC output is already the final result.
                if (cnt_q == '0) begin
                    bin_d   = mac_sum;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
                    err_d   = flag_d;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bin       = bin_q;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    assign err       = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
// +----------------------------------------------------------------------+
// | tb_bcd_to_bin : randomized self-checking bench for bcd_to_bin         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bcd_to_bin;

    localparam int DIGITS = 3;
    localparam int BW     = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bcd;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  bin;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    bcd_to_bin #(
        .DIGITS (DIGITS),
        .BW     (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd       (bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin       (bin)
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Decimal value of a packed word: sum of digit * 10**position, wrapped to BW bits.
    function automatic int unsigned ref_bin(input logic [11:0] w);
        int unsigned v;
        int unsigned p;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v = v + int'(w[i*4 +: 4]) * p;
            p = p * 10;
        end
        return v % (1 << BW);
    endfunction

    function automatic logic ref_err(input logic [11:0] w);
        logic e;
        e = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w[i*4 +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [11:0] rand_bcd();
        logic [11:0] w;
        for (int i = 0; i < DIGITS; i++) begin
            w[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    // One full transaction with out_ready high; starts and ends in IDLE.
    task automatic run_word(input logic [11:0] w, input string tag);
        int lat;
        in_valid = 1'b1;
        bcd      = w;
        check_eq({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        bcd      = 12'($urandom);
        check_eq({tag, "_busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, DIGITS);
        check_eq({tag, "_bin"}, bin, ref_bin(w));
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        check_eq({tag, "_err"}, err, ref_err(w));
`endif
        tick();
        check_eq({tag, "_ovl_clr"}, out_valid, 0);
        check_eq({tag, "_rdy_back"}, in_ready, 1);
    endtask

    initial begin
        int          lat;
        logic [11:0] w2;
        int          sent;
        int          got;
        int          last_acc;
        logic        acc_prev;
        int unsigned expq[$];
        logic        seen_out;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bcd       = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_bin", bin, 0);
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        check_eq("rst_err", err, 0);
`endif

        run_word(12'h255, "w255");
        run_word(12'h000, "w000");
        run_word(12'h999, "w999");
        run_word(12'h001, "w001");
        run_word(12'h0A0, "w0A0");
        run_word(12'h123, "w123");
        for (int k = 0; k < 4; k++) begin
            run_word(12'($urandom), "wrand");
        end

        // Back-pressure: stall the consumer, wiggle the input side.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bcd       = 12'h437;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("bp_lat", lat, DIGITS);
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'($urandom);
            bcd      = 12'($urandom);
            tick();
            check_eq("bp_ovl", out_valid, 1);
            check_eq("bp_bin", bin, 437);
            check_eq("bp_rdy", in_ready, 0);
        end
        w2        = 12'h562;
        in_valid  = 1'b1;
        bcd       = w2;
        out_ready = 1'b1;
        tick();
        check_eq("bp_release_rdy", in_ready, 1);
        check_eq("bp_release_ovl", out_valid, 0);
        tick();
        in_valid = 1'b0;
        check_eq("bp_second_acc", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("bp_second_bin", bin, ref_bin(w2));
        tick();

        // Reset one cycle after accepting 812.
        in_valid = 1'b1;
        bcd      = 12'h812;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_rdy", in_ready, 1);
        check_eq("mrst_ovl", out_valid, 0);
        check_eq("mrst_bin", bin, 0);
        seen_out = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid) seen_out = 1'b1;
        end
        check_eq("mrst_no_output", seen_out, 0);

        // Throughput: continuous valid/ready, 20 random words.
        sent     = 0;
        got      = 0;
        last_acc = -1;
        acc_prev = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bcd       = rand_bcd();
        for (int k = 0; k < 300 && got < 20; k++) begin
            if (out_valid) begin
                if (expq.size() > 0) begin
                    check_eq("tp_bin", bin, expq.pop_front());
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
                    check_eq("tp_err", err, 0);
`endif
                end else begin
                    check_eq("tp_unexpected_out", 1, 0);
                end
                got++;
            end
            if (acc_prev) bcd = rand_bcd();
            acc_prev = 1'b0;
            if (in_ready && in_valid && sent < 20) begin
                expq.push_back(ref_bin(bcd));
                if (last_acc >= 0) check_eq("tp_gap", cyc - last_acc, DIGITS + 2);
                last_acc = cyc;
                acc_prev = 1'b1;
                sent++;
                if (sent == 20) begin
                    tick();
                    in_valid = 1'b0;
                    continue;
                end
            end
            tick();
        end
        check_eq("tp_count", got, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential packed-BCD to unsigned-binary converter; inverse of the display-path binary-to-BCD converter.
- Used where decimal operator entry (keypad, rotary digits, UART decimal fields) must become a binary value for counters and arithmetic.
- Iterative multiply-by-10-and-add, one digit per clock, most significant digit first.
- Valid/ready handshake on both sides.

Parameters:
- DIGITS, 3, number of BCD digits in the input word (>= 1).
- BW, 10, output width; must satisfy 2**BW >= 10**DIGITS for exact results, otherwise the result is taken modulo 2**BW.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- bcd  in  DIGITS*4  packed BCD; digit DIGITS-1 in the MS nibble.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- bin  out  BW  binary result.
- err  out  1  invalid-digit flag; present only with the optional feature.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; in_ready=1, out_valid=0, bin=0, err=0; digit counter and accumulator cleared.
- Reset takes priority over every other event and aborts any conversion in progress; the aborted word produces no output.
- FSM states:
  - IDLE:
    - in_ready=1, out_valid=0.
    - When in_valid&&in_ready at an edge: latch bcd into a shift register, set acc=0, set cnt=DIGITS-1, go to CONV.
  - CONV:
    - in_ready=0, out_valid=0.
    - Each edge: acc <= (acc<<3)+(acc<<1)+msd, computed at BW bits, where msd is the top nibble of the shift register.
    - Shift register moves left by 4 bits; cnt decrements.
    - On the edge where cnt==0: bin <= final acc, go to DONE.
  - DONE:
    - out_valid=1; bin is stable and held; in_ready=0.
    - When out_valid&&out_ready at an edge: go to IDLE.
- Timing: handshake at edge T, conversion edges T+1..T+DIGITS, out_valid=1 from edge T+DIGITS.
  - Latency is DIGITS cycles from acceptance to out_valid.
  - Minimum period between accepted words is DIGITS+2 cycles.
- in_ready and out_valid are never high together, so input and output handshakes cannot happen in the same cycle.
- bcd is sampled only at the accept edge. Later changes to bcd do not affect the result.
- in_valid is ignored outside IDLE.
- out_ready is ignored outside DONE. out_ready held high makes DONE last exactly one cycle.
- Digits 0xA–0xF are not rejected; their nibble value is used arithmetically.
  - Example: 12'h0A0 gives 100.
  - Result wraps modulo 2**BW.
- bin keeps its last value in IDLE/CONV; it is meaningful only while out_valid=1.

Optional Feature:
- Macro BCD_TO_BIN_DIGIT_CHECK_EN.
- Defined:
  - err port exists.
  - An internal sticky flag is cleared on accept and set in CONV when any msd > 9.
  - err <= flag at the transition to DONE; err is valid with out_valid and held with it.
  - err resets to 0.
  - bin is still computed as in the undefined case.
- Undefined: no err port, no checking logic.

Decomposition:
- Package bcd_pkg:
  - typedef logic [3:0] bcd_digit_t.
  - enum typedef conv_state_t {IDLE, CONV, DONE}.
  - localparam bcd_digit_t BCD_MAX = 4'd9.
  - helper function digits_to_bw(DIGITS) for parameter sanity checks.
- One combinational sub-module, bcd_mac10: acc (BW) and digit (4) in, acc*10+digit (BW) out, using shift-add only, no multiplier.

Test Plan:
- DIGITS=3, BW=10, out_ready=1, bcd=12'h255 accepted at cycle 0 -> out_valid high after 3 conversion edges, bin=255 for 1 cycle, in_ready back high the next cycle.
- Boundaries: bcd=12'h000 -> bin=0; bcd=12'h999 -> bin=999; bcd=12'h001 -> bin=1.
- Back-pressure:
  - Stimulus: bcd=12'h437, out_ready held 0 for 6 cycles after out_valid, and bcd/in_valid toggled during the stall.
  - Response: out_valid and bin=437 stay stable, in_ready stays 0, and the second word is accepted only after the out_ready handshake.
- Reset mid-conversion: rst=1 one cycle after accepting 12'h812 -> the next cycle shows in_ready=1, out_valid=0, bin=0; no result is ever emitted for 812.
- Invalid digit: bcd=12'h0A0 -> bin=100.
  - With BCD_TO_BIN_DIGIT_CHECK_EN: err=1.
  - A following 12'h123 -> bin=123, err=0.
- Throughput: in_valid and out_ready held 1 with 20 random valid-BCD words -> every output matches the decimal value in order, and accepts occur every 5 cycles.
